// File: rtl/npc_dmem_resp.sv
// rtl/npc_dmem_resp.sv - data memory responder: doubleword RAM, UART TX byte FIFO, cycle timer
module npc_dmem_resp #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [63:0] mem_raddr,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        addr_err
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Doubleword (addr[63:3]) addresses of the mapped regions
  localparam logic [60:0] RAM_BASE_W = 61'h1000_0000;
  localparam logic [60:0] RAM_SIZE_W = 61'(RAM_WORDS);
  localparam logic [60:0] TXDATA_W   = 61'h1400_0000;
  localparam logic [60:0] STATUS_W   = 61'h1400_0001;
  localparam logic [60:0] TIMER_W    = 61'h1400_0002;

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [63:0] ram_mem [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [63:0]   timer_q, timer_d;

  logic [60:0]   rword, wword, roff, woff;
  logic          r_is_ram, w_is_ram;
  logic [AW-1:0] ridx, widx;
  logic          rd_en, wr_en, rd_unmapped;
  logic          ram_we, push, push_ok, pop, timer_ld, wr_bad;
  logic          fifo_full, fifo_empty;
  logic [3:0]    cnt4;
  logic [63:0]   status_word;
  logic          unused_low_bits;

  // Byte offset within a doubleword never affects decode
  assign unused_low_bits = ^{mem_raddr[2:0], mem_waddr[2:0]};

  // An address below the base wraps to a huge offset, so one compare bounds both ends
  assign rword    = mem_raddr[63:3];
  assign wword    = mem_waddr[63:3];
  assign roff     = rword - RAM_BASE_W;
  assign woff     = wword - RAM_BASE_W;
  assign r_is_ram = (roff < RAM_SIZE_W);
  assign w_is_ram = (woff < RAM_SIZE_W);
  assign ridx     = roff[AW-1:0];
  assign widx     = woff[AW-1:0];

  assign rd_en = rst_n & mem_ce & ~mem_we;
  assign wr_en = rst_n & mem_ce & mem_we;

  assign fifo_full   = (count_q == FULL_CNT);
  assign fifo_empty  = (count_q == '0);
  assign cnt4        = 4'(count_q);
  assign status_word = {56'd0, cnt4, 1'b0, ovf_q, fifo_empty, fifo_full};

  assign uart_tx_valid = rst_n & ~fifo_empty;
  assign uart_tx_data  = fifo_mem[rptr_q];
  assign addr_err      = err_q;

  assign ram_we   = wr_en & w_is_ram;
  assign push     = wr_en & (wword == TXDATA_W);
  assign timer_ld = wr_en & (wword == TIMER_W);
  assign wr_bad   = wr_en & ~w_is_ram & (wword != TXDATA_W) & (wword != TIMER_W);
  assign pop      = uart_tx_valid & uart_tx_ready;
  assign push_ok  = push & (~fifo_full | pop);

  // Combinational read mux; unmapped reads return zero and flag an error
  always_comb begin
    mem_rdata   = '0;
    rd_unmapped = 1'b0;
    if (rd_en) begin
      if (r_is_ram)                mem_rdata = ram_mem[ridx];
      else if (rword == TXDATA_W)  mem_rdata = '0;
      else if (rword == STATUS_W)  mem_rdata = status_word;
      else if (rword == TIMER_W)   mem_rdata = timer_q;
      else                         rd_unmapped = 1'b1;
    end
  end

  // Next-state for FIFO bookkeeping, sticky flags and the timer
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q | rd_unmapped | wr_bad;
    timer_d = timer_ld ? mem_wdata : timer_q + 64'd1;
    if (pop)     rptr_d = rptr_q + PTR_ONE;
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (push & ~push_ok) ovf_d = 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Storage arrays are not reset; writes are already gated by rst_n
  always_ff @(posedge clk) begin
    if (ram_we)  ram_mem[widx]    <= mem_wdata;
    if (push_ok) fifo_mem[wptr_q] <= mem_wdata[7:0];
  end

endmodule

// File: tb/tb_npc_dmem_resp.sv
// tb/tb_npc_dmem_resp.sv - randomized and directed bench for npc_dmem_resp against a queue-based model
module tb_npc_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ce, mem_we;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_tx_data;
  logic        addr_err;

  npc_dmem_resp #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(uart_tx_ready), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] A_TX     = 64'hA000_0000;
  localparam logic [63:0] A_STATUS = 64'hA000_0008;
  localparam logic [63:0] A_TIMER  = 64'hA000_0010;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_ram [256];
  logic [7:0]  m_fifo [$];
  logic [63:0] m_timer;
  bit          m_ovf, m_err;

  // Last sampled DUT outputs
  logic [63:0] obs_rdata;
  logic [7:0]  obs_tx;
  logic        obs_valid, obs_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 ram, 1 txdata, 2 status, 3 timer, 4 unmapped
  function automatic int kind_of(input logic [63:0] a);
    logic [63:0] d;
    d = {a[63:3], 3'b000};
    if (d >= 64'h8000_0000 && d < 64'h8000_0000 + 64'd2048) return 0;
    if (d == A_TX)     return 1;
    if (d == A_STATUS) return 2;
    if (d == A_TIMER)  return 3;
    return 4;
  endfunction

  function automatic int ram_index(input logic [63:0] a);
    return int'((a - 64'h8000_0000) >> 3);
  endfunction

  function automatic logic [63:0] model_status();
    logic [63:0] s;
    s = 64'(m_fifo.size()) << 4;
    if (m_ovf) s = s + 64'h4;
    if (m_fifo.size() == 0) s = s + 64'h2;
    if (m_fifo.size() == 8) s = s + 64'h1;
    return s;
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a);
    case (kind_of(a))
      0:       return m_ram[ram_index(a)];
      2:       return model_status();
      3:       return m_timer;
      default: return 64'd0;
    endcase
  endfunction

  // One clock cycle: drive, sample mid-cycle against the model, advance the model at the edge
  task automatic step(input logic ce, input logic we, input logic [63:0] ra, input logic [63:0] wa,
                      input logic [63:0] wd, input logic rdy, input logic rn);
    logic [63:0] exp_rd;
    bit          pop, push_acc, load;
    mem_ce = ce; mem_we = we; mem_raddr = ra; mem_waddr = wa; mem_wdata = wd;
    uart_tx_ready = rdy; rst_n = rn;
    #2;
    exp_rd = (rn && ce && !we) ? model_read(ra) : 64'd0;
    obs_rdata = mem_rdata; obs_tx = uart_tx_data; obs_valid = uart_tx_valid; obs_err = addr_err;
    check_eq("rdata", mem_rdata, exp_rd);
    check_eq("tx_valid", 64'(uart_tx_valid), 64'(rn && m_fifo.size() != 0));
    if (rn && m_fifo.size() != 0) check_eq("tx_data", 64'(uart_tx_data), 64'(m_fifo[0]));
    check_eq("addr_err", 64'(addr_err), 64'(m_err));
    @(posedge clk);
    if (!rn) begin
      m_fifo.delete(); m_timer = 64'd0; m_ovf = 1'b0; m_err = 1'b0;
    end else begin
      pop = (m_fifo.size() > 0) && rdy;
      push_acc = 1'b0; load = 1'b0;
      if (ce && we) begin
        case (kind_of(wa))
          0: m_ram[ram_index(wa)] = wd;
          1: if (m_fifo.size() < 8 || pop) push_acc = 1'b1; else m_ovf = 1'b1;
          3: load = 1'b1;
          default: m_err = 1'b1;
        endcase
      end
      if (ce && !we && kind_of(ra) == 4) m_err = 1'b1;
      if (pop) void'(m_fifo.pop_front());
      if (push_acc) m_fifo.push_back(wd[7:0]);
      m_timer = load ? wd : m_timer + 64'd1;
    end
    #1;
  endtask

  task automatic rd(input logic [63:0] a, input logic rdy);
    step(1'b1, 1'b0, a, 64'd0, 64'd0, rdy, 1'b1);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic rdy);
    step(1'b1, 1'b1, 64'd0, a, d, rdy, 1'b1);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, rdy, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] low;
    low = 64'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0, 1: return 64'h8000_0000 + (64'($urandom_range(0, 255)) << 3) + low;
      2:    return A_TX | low;
      3:    return A_STATUS | low;
      4:    return A_TIMER | low;
      5:    return ($urandom_range(0, 1) == 0) ? 64'h8000_0800 + low : 64'h7FFF_FFF8 + low;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] wd;
    mem_ce = 0; mem_we = 0; mem_raddr = 0; mem_waddr = 0; mem_wdata = 0;
    uart_tx_ready = 0; rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    m_fifo.delete(); m_timer = 0; m_ovf = 0; m_err = 0;

    // Reset state: first cycle after release
    rd(A_TIMER, 1'b0);
    check_eq("reset_timer", obs_rdata, 64'd0);
    check_eq("reset_valid", 64'(obs_valid), 64'd0);
    check_eq("reset_err", 64'(obs_err), 64'd0);
    rd(A_STATUS, 1'b0);
    check_eq("reset_status", obs_rdata, 64'h02);

    // Fill every RAM word so all later reads are defined
    for (int i = 0; i < 256; i++) wr(64'h8000_0000 + 64'(i * 8), {$urandom, $urandom}, 1'b0);

    // RAM write and readback, read during write returns zero on the bus
    rd(64'h8000_0010, 1'b0);
    step(1'b1, 1'b1, 64'h8000_0013, 64'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
    rd(64'h8000_0013, 1'b0);
    check_eq("ram_readback", obs_rdata, 64'h1122_3344_5566_7788);

    // FIFO fill and overflow
    for (int i = 0; i < 9; i++) wr(A_TX, 64'h41 + 64'(i), 1'b0);
    rd(A_STATUS, 1'b0);
    check_eq("status_overflow", obs_rdata, 64'h85);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check_eq("drain_byte", 64'(obs_tx), 64'h41 + 64'(i));
    end
    rd(A_STATUS, 1'b0);
    check_eq("drain_empty", 64'(obs_valid), 64'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) wr(A_TX, 64'h50 + 64'(i), 1'b0);
    wr(A_TX, 64'h5A, 1'b1);
    rd(A_STATUS, 1'b0);
    check_eq("full_push_pop", obs_rdata, 64'h81);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check_eq("last_byte", 64'(obs_tx), 64'h5A);

    // Timer load and wrap
    wr(A_TIMER, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    rd(A_TIMER, 1'b0);
    check_eq("timer_load", obs_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(A_TIMER, 1'b0);
    check_eq("timer_max", obs_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(A_TIMER, 1'b0);
    check_eq("timer_wrap", obs_rdata, 64'd0);

    // Unmapped read, then write to STATUS
    rd(64'h0000_1000, 1'b0);
    check_eq("unmapped_rdata", obs_rdata, 64'd0);
    check_eq("err_before", 64'(obs_err), 64'd0);
    idle(1'b0);
    check_eq("err_set", 64'(obs_err), 64'd1);
    idle(1'b0);
    check_eq("err_sticky", 64'(obs_err), 64'd1);
    do_reset();
    wr(A_STATUS, 64'hFF, 1'b0);
    rd(A_STATUS, 1'b0);
    check_eq("status_wr_err", 64'(obs_err), 64'd1);
    check_eq("status_unchanged", obs_rdata, 64'h02);

    // Reset mid-operation
    do_reset();
    wr(64'h8000_0100, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) wr(A_TX, 64'h61 + 64'(i), 1'b0);
    wr(A_TIMER, 64'd497, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    rd(A_TIMER, 1'b0);
    check_eq("timer_500", obs_rdata, 64'd500);
    do_reset();
    rd(A_TIMER, 1'b0);
    check_eq("rst_timer", obs_rdata, 64'd0);
    check_eq("rst_valid", 64'(obs_valid), 64'd0);
    rd(A_STATUS, 1'b0);
    check_eq("rst_status", obs_rdata, 64'h02);
    rd(64'h8000_0100, 1'b0);
    check_eq("rst_ram_kept", obs_rdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) wd = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_addr(), rand_addr(),
           wd, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
